// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: width codes, FSM encodings,
// bus command payload and legality helpers.
package load_store_unit_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQUEST = 2'd1;
  localparam logic [1:0] ST_RESPOND = 2'd2;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } mem_cmd_t;

  function automatic logic lsu_illegal(input logic is_store, input logic [2:0] funct3);
    return (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
           (is_store && funct3[2]);
  endfunction

  function automatic logic lsu_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    return (((funct3 == LSU_H) || (funct3 == LSU_HU)) && offset[0]) ||
           ((funct3 == LSU_W) && (offset != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Byte-lane steering: store strobes and replication, load lane select and extension.
module lsu_data_align
  import load_store_unit_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb_c,
  output logic [31:0] wdata_c,
  output logic [31:0] load_c
);

  logic [31:0] shifted;

  assign shifted = rdata >> {offset, 3'b000};

  always_comb begin
    wstrb_c = '0;
    wdata_c = '0;
    if (is_store) begin
      case (funct3[1:0])
        2'b00: begin
          wstrb_c = 4'b0001 << offset;
          wdata_c = {4{store_data[7:0]}};
        end
        2'b01: begin
          wstrb_c = 4'b0011 << offset;
          wdata_c = {2{store_data[15:0]}};
        end
        2'b10: begin
          wstrb_c = 4'b1111;
          wdata_c = store_data;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    load_c = '0;
    case (funct3)
      LSU_B:   load_c = {{24{shifted[7]}}, shifted[7:0]};
      LSU_BU:  load_c = {24'h0, shifted[7:0]};
      LSU_H:   load_c = {{16{shifted[15]}}, shifted[15:0]};
      LSU_HU:  load_c = {16'h0, shifted[15:0]};
      LSU_W:   load_c = rdata;
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one request/ready bus transaction per accepted start,
// with legality checks, timeout abort and extended load return.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        illegal,
  output logic        bus_error,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             is_store_q, is_store_nx;
  logic [2:0]       funct3_q, funct3_nx;
  logic [1:0]       offset_q, offset_nx;
  mem_cmd_t         cmd_q, cmd_nx;
  logic             req_nx, busy_nx, done_nx;
  logic             misaligned_nx, illegal_nx, bus_error_nx;
  logic [31:0]      load_data_nx;

  logic             idle;
  logic [3:0]       wstrb_c;
  logic [31:0]      wdata_c, load_c;

  // In IDLE the aligner sees the live request; afterwards the latched copy.
  assign idle = (state == ST_IDLE);

  lsu_data_align u_align (
    .is_store   (idle ? is_store : is_store_q),
    .funct3     (idle ? funct3 : funct3_q),
    .offset     (idle ? address[1:0] : offset_q),
    .store_data (store_data),
    .rdata      (mem_rdata),
    .wstrb_c    (wstrb_c),
    .wdata_c    (wdata_c),
    .load_c     (load_c)
  );

  assign mem_we    = cmd_q.we;
  assign mem_addr  = cmd_q.addr;
  assign mem_wstrb = cmd_q.wstrb;
  assign mem_wdata = cmd_q.wdata;

  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    is_store_nx   = is_store_q;
    funct3_nx     = funct3_q;
    offset_nx     = offset_q;
    cmd_nx        = '0;
    req_nx        = 1'b0;
    misaligned_nx = 1'b0;
    illegal_nx    = 1'b0;
    bus_error_nx  = 1'b0;
    load_data_nx  = '0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          is_store_nx = is_store;
          funct3_nx   = funct3;
          offset_nx   = address[1:0];
          cnt_nx      = '0;
          if (lsu_illegal(is_store, funct3)) begin
            illegal_nx = 1'b1;
            state_nx   = ST_RESPOND;
          end else if (lsu_misaligned(funct3, address[1:0])) begin
            misaligned_nx = 1'b1;
            state_nx      = ST_RESPOND;
          end else begin
            state_nx     = ST_REQUEST;
            req_nx       = 1'b1;
            cmd_nx.we    = is_store;
            cmd_nx.addr  = {address[31:2], 2'b00};
            cmd_nx.wstrb = wstrb_c;
            cmd_nx.wdata = wdata_c;
          end
        end
      end
      ST_REQUEST: begin
        // A ready on the final allowed cycle still counts as success.
        if (mem_ready) begin
          state_nx = ST_RESPOND;
          if (!is_store_q) load_data_nx = load_c;
        end else if (cnt == CNT_LAST) begin
          state_nx     = ST_RESPOND;
          bus_error_nx = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
          req_nx = 1'b1;
          cmd_nx = cmd_q;
        end
      end
      ST_RESPOND: state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
    busy_nx = (state_nx != ST_IDLE);
    done_nx = (state_nx == ST_RESPOND);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      is_store_q <= 1'b0;
      funct3_q   <= '0;
      offset_q   <= '0;
      cmd_q      <= '0;
      mem_req    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      misaligned <= 1'b0;
      illegal    <= 1'b0;
      bus_error  <= 1'b0;
      load_data  <= '0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      is_store_q <= is_store_nx;
      funct3_q   <= funct3_nx;
      offset_q   <= offset_nx;
      cmd_q      <= cmd_nx;
      mem_req    <= req_nx;
      busy       <= busy_nx;
      done       <= done_nx;
      misaligned <= misaligned_nx;
      illegal    <= illegal_nx;
      bus_error  <= bus_error_nx;
      load_data  <= load_data_nx;
    end
  end

endmodule
